// File: rtl/gray_counter_chk.sv
// Up/down binary counter with registered Gray output, plus an optional checker that
// flags multi-bit jumps on an external Gray stream (enable with GRAY_COUNTER_CHK_CHECK_EN).
module gray_counter_chk #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX  = '1;

  logic [WIDTH-1:0] bin_next;
  logic             wrap_next;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    bin_next  = bin_out;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = load_bin;
    end else if (en) begin
      if (up) begin
        bin_next  = bin_out + ONE;
        wrap_next = (bin_out == MAX);
      end else begin
        bin_next  = bin_out - ONE;
        wrap_next = (bin_out == ZERO);
      end
    end
  end

  // Gray is derived from the next binary value so both registers change on the same edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out  <= '0;
      gray_out <= '0;
      wrap     <= 1'b0;
    end else begin
      bin_out  <= bin_next;
      gray_out <= bin_next ^ (bin_next >> 1);
      wrap     <= wrap_next;
    end
  end

`ifdef GRAY_COUNTER_CHK_CHECK_EN
  logic [WIDTH-1:0] gray_in_q;
  logic             prime;
  logic             violation;

  // prime keeps the reset value of gray_in_q from being compared as if it were a real sample.
  assign violation = prime && ($countones(gray_in ^ gray_in_q) > 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_in_q <= '0;
      prime     <= 1'b0;
      err       <= 1'b0;
    end else begin
      gray_in_q <= gray_in;
      prime     <= 1'b1;
      err       <= violation | (err & ~clr_err);
    end
  end
`else
  logic unused_checker_inputs;
  assign unused_checker_inputs = ^{gray_in, clr_err};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter_chk.sv
// Self-checking bench for gray_counter_chk (WIDTH=4): directed steps followed by randomized
// traffic compared against an integer-arithmetic reference model.
module tb_gray_counter_chk;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up, load, clr_err;
  logic [3:0] load_bin, gray_in;
  logic [3:0] bin_out, gray_out;
  logic       wrap, err;

  int checks = 0;
  int errors = 0;

  // reference model state
  int   m_cnt;
  bit   m_wrap, m_err, m_prime;
  int   m_gq;

  gray_counter_chk #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .clr_err(clr_err), .gray_in(gray_in), .bin_out(bin_out), .gray_out(gray_out),
    .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int gray_of(input int n);
    return n ^ (n >> 1);
  endfunction

  function automatic int bits_diff(input int a, input int b);
    int c = 0;
    for (int i = 0; i < 4; i++) if (((a >> i) & 1) != ((b >> i) & 1)) c++;
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_wrap = 0; m_err = 0; m_prime = 0; m_gq = 0;
  endtask

  // One clock: advance the model on the edge with the inputs the DUT sees, then compare.
  task automatic tick(input string tag);
    @(posedge clk);
    if (load) begin
      m_cnt = int'(load_bin); m_wrap = 0;
    end else if (en) begin
      if (up) begin m_wrap = (m_cnt == 15); m_cnt = (m_cnt + 1) % 16; end
      else    begin m_wrap = (m_cnt == 0);  m_cnt = (m_cnt + 15) % 16; end
    end else begin
      m_wrap = 0;
    end
`ifdef GRAY_COUNTER_CHK_CHECK_EN
    if (m_prime && bits_diff(int'(gray_in), m_gq) > 1) m_err = 1;
    else if (clr_err) m_err = 0;
    m_gq = int'(gray_in);
    m_prime = 1;
`endif
    #1;
    check({tag, ".bin"},  bin_out,  m_cnt);
    check({tag, ".gray"}, gray_out, gray_of(m_cnt));
    check({tag, ".wrap"}, wrap,     m_wrap);
    check({tag, ".err"},  err,      m_err);
  endtask

  task automatic run_up16(input string tag);
    logic [3:0] exp_seq [16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
    en = 1; up = 1; load = 0;
    for (int i = 0; i < 16; i++) begin
      tick(tag);
      check({tag, ".seq_gray"}, gray_out, exp_seq[i]);
      check({tag, ".seq_wrap"}, wrap, (i == 15));
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 0; up = 1; load = 0; clr_err = 0; load_bin = 0; gray_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.bin", bin_out, 0);
    check("rst.gray", gray_out, 0);
    check("rst.wrap", wrap, 0);
    check("rst.err", err, 0);
    @(negedge clk) rst_n = 1'b1;

    // count up through a full cycle including wrap-around
    run_up16("up16");

    // load has priority over en/up, then hold
    load = 1; load_bin = 4'd9; en = 1; up = 0;
    tick("load9");
    check("load9.bin", bin_out, 9);
    check("load9.gray", gray_out, 13);
    check("load9.wrap", wrap, 0);
    load = 0; en = 0;
    for (int i = 0; i < 3; i++) begin
      tick("hold");
      check("hold.bin", bin_out, 9);
    end

    // down-count wrap from 0
    load = 1; load_bin = 0;
    tick("load0");
    load = 0; en = 1; up = 0;
    tick("down_wrap");
    check("down_wrap.bin", bin_out, 15);
    check("down_wrap.gray", gray_out, 8);
    check("down_wrap.wrap", wrap, 1);
    tick("down_after");
    check("down_after.wrap", wrap, 0);

    // Gray-stream checker
    en = 0;
`ifdef GRAY_COUNTER_CHK_CHECK_EN
    gray_in = 0; tick("chk0");
    gray_in = 1; tick("chk1");
    gray_in = 3; tick("chk3");
    gray_in = 3; tick("chk3b");
    check("chk.no_err", err, 0);
    gray_in = 0; tick("chk_jump");
    check("chk.err_set", err, 1);
    tick("chk_sticky");
    check("chk.err_sticky", err, 1);
    clr_err = 1; tick("chk_clr");
    check("chk.err_clr", err, 0);
    gray_in = 15; tick("chk_setwins");
    check("chk.set_wins", err, 1);
    clr_err = 1; tick("chk_clr2");
    clr_err = 0;
    check("chk.err_clr2", err, 0);
`else
    gray_in = 0;  tick("nochk0");
    gray_in = 15; tick("nochk15");
    tick("nochk15b");
    check("nochk.err", err, 0);
    clr_err = 1; tick("nochk_clr");
    clr_err = 0;
`endif

    // repeat the up sequence from 0
    load = 1; load_bin = 0; tick("reload0");
    run_up16("up16b");

    // asynchronous reset mid-count
    load = 1; load_bin = 0; tick("pre_rst");
    load = 0; en = 1; up = 1;
    for (int i = 0; i < 6; i++) tick("to6");
    check("to6.bin", bin_out, 6);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async.bin", bin_out, 0);
    check("async.gray", gray_out, 0);
    check("async.wrap", wrap, 0);
    check("async.err", err, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick("resume");
      check("resume.bin", bin_out, i);
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      load     = ($urandom_range(0, 9) == 0);
      load_bin = 4'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      up       = 1'($urandom_range(0, 1));
      clr_err  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) gray_in = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 3) == 0) gray_in = gray_in;
      else gray_in = gray_in ^ (4'b0001 << $urandom_range(0, 3));
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_counter_chk.md
GRAY_COUNTER_CHK -- requirements
Module: gray_counter_chk

Interface
REQ-001 Parameter WIDTH, default 4, sets the counter and code width in bits; legal range 2..16.
REQ-002 clk  input  1  sole clock; all flops update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset; one clock, reset asynchronous and active-low.
REQ-004 en  input  1  count enable: advance one step per cycle while high.
REQ-005 up  input  1  direction: 1 counts up, 0 counts down; sampled only when en=1.
REQ-006 load  input  1  synchronous load strobe.
REQ-007 load_bin  input  WIDTH  binary value loaded when load=1.
REQ-008 clr_err  input  1  synchronous clear of err.
REQ-009 gray_in  input  WIDTH  external Gray stream monitored by the checker.
REQ-010 bin_out  output  WIDTH  registered binary count.
REQ-011 gray_out  output  WIDTH  registered Gray code of bin_out, feeding the downstream Gray-to-binary stage.
REQ-012 wrap  output  1  one-cycle pulse on counter wrap-around.
REQ-013 err  output  1  sticky flag: gray_in changed more than one bit between consecutive samples.

Function
REQ-014 bin_out and gray_out SHALL be registered and SHALL update on the same clk edge; gray_out SHALL always equal bin_out ^ (bin_out >> 1), with no cycle in which they disagree.
REQ-015 Latency: a change caused by en or load in cycle N SHALL appear on the outputs after the rising edge ending cycle N (1 cycle).
REQ-016 Priority: load over en; with load=1, bin_out <= load_bin and gray_out <= Gray(load_bin), regardless of en and up.
REQ-017 With load=0 and en=1, up=1: bin_out <= (bin_out+1) mod 2^WIDTH; up=0: bin_out <= (bin_out-1) mod 2^WIDTH.
REQ-018 With load=0 and en=0: bin_out and gray_out hold.
REQ-019 wrap SHALL be 1 for exactly one cycle after a step from 2^WIDTH-1 to 0 (up) or from 0 to 2^WIDTH-1 (down); otherwise 0, including on every load cycle.
REQ-020 Each counted step SHALL change exactly one bit of gray_out, including across the wrap-around.
REQ-021 Checker: gray_in SHALL be registered every cycle into gray_in_q; a prime flag SHALL set on the first sample after reset.
REQ-022 err SHALL set on the edge after a cycle in which prime=1 and popcount(gray_in ^ gray_in_q) > 1; zero- or one-bit changes SHALL NOT set it.
REQ-023 err SHALL stay 1 until clr_err or reset; if clr_err and a new violation coincide, err SHALL remain 1 (set wins).

Reset
REQ-024 rst_n=0 SHALL immediately, without a clock edge, force bin_out=0, gray_out=0, wrap=0, err=0, gray_in_q=0 and prime=0.
REQ-025 Reset asserted mid-count SHALL abandon the count; the first edge after rst_n rises SHALL obey REQ-016..REQ-018 from a count of 0.

Configuration
REQ-026 Macro GRAY_COUNTER_CHK_CHECK_EN compiles in the checker (REQ-021..REQ-023).
REQ-027 Without the macro: gray_in and clr_err SHALL be ignored, err SHALL be tied to 0, and the gray_in_q/prime/err flops SHALL NOT exist; counter behaviour SHALL be identical.

Verification (WIDTH=4)
REQ-028 Reset, then en=1, up=1 for 16 cycles -> gray_out 1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,0; wrap=1 only in the cycle in which bin_out=0.
REQ-029 load=1, load_bin=9, en=1, up=0 -> next cycle bin_out=9, gray_out=13, wrap=0; then en=0 for 3 cycles -> values hold.
REQ-030 From bin_out=0: en=1, up=0 -> bin_out=15, gray_out=8, wrap=1 for one cycle.
REQ-031 With the macro defined: gray_in 0 -> 1 -> 3 -> 3 -> err stays 0; then 3 -> 0 -> err=1 on the next edge and stays 1; clr_err=1 for one cycle -> err=0.
REQ-032 Count up to bin_out=6, then drop rst_n between clock edges -> bin_out=0, gray_out=0, err=0 before the next edge; release -> counting resumes 1,2,...
REQ-033 Macro undefined: drive gray_in 0 -> 15 -> err remains 0; repeat REQ-028 and get an identical sequence.
